// File: rtl/fp_align_denorm.sv
// Multi-cycle FP32 operand aligner: right-shifts the smaller-exponent mantissa
// STEP bits per cycle until both operands share the larger exponent, keeping G/R/S.
module fp_align_denorm #(
    parameter int STEP      = 4,
    parameter int MAX_SHIFT = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  exp_out,
    output logic        sign_big,
    output logic        sign_small,
    output logic [26:0] mant_big,
    output logic [26:0] mant_small,
    output logic        swapped,
    output logic        special
);

    localparam int REM_W = $clog2(MAX_SHIFT + 1);
    localparam logic [REM_W-1:0] STEP_R = REM_W'(STEP);
    localparam logic [REM_W-1:0] MAX_R  = REM_W'(MAX_SHIFT);
    localparam logic [7:0]       MAX_8  = 8'(MAX_SHIFT);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [REM_W-1:0] rem;

    logic [7:0]       exp_a, exp_b, eff_a, eff_b, diff;
    logic [26:0]      mant_a, mant_b;
    logic             a_big, special_in;
    logic [REM_W-1:0] rem_init;

    // Zero exponent (denormal/zero) behaves as exponent 1 for ordering and distance.
    assign exp_a      = a[30:23];
    assign exp_b      = b[30:23];
    assign eff_a      = (exp_a == 8'd0) ? 8'd1 : exp_a;
    assign eff_b      = (exp_b == 8'd0) ? 8'd1 : exp_b;
    assign mant_a     = {(exp_a != 8'd0), a[22:0], 3'b000};
    assign mant_b     = {(exp_b != 8'd0), b[22:0], 3'b000};
    assign a_big      = (eff_a >= eff_b);
    assign diff       = a_big ? (eff_a - eff_b) : (eff_b - eff_a);
    assign rem_init   = (diff >= MAX_8) ? MAX_R : REM_W'(diff);
    assign special_in = (&exp_a) | (&exp_b);

    logic [REM_W-1:0] k;
    logic [26:0]      shifted, mask, mant_next;
    logic             sticky;

    // Bit 0 of the result absorbs every bit shifted out, including the prior sticky.
    assign k         = (rem >= STEP_R) ? STEP_R : rem;
    assign shifted   = mant_small >> k;
    assign mask      = (27'd1 << k) - 27'd1;
    assign sticky    = |(mant_small & mask);
    assign mant_next = shifted | {26'd0, sticky};

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rem        <= '0;
            out_valid  <= 1'b0;
            exp_out    <= 8'd0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            mant_big   <= 27'd0;
            mant_small <= 27'd0;
            swapped    <= 1'b0;
            special    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        exp_out    <= a_big ? exp_a : exp_b;
                        sign_big   <= a_big ? a[31] : b[31];
                        sign_small <= a_big ? b[31] : a[31];
                        mant_big   <= a_big ? mant_a : mant_b;
                        mant_small <= a_big ? mant_b : mant_a;
                        swapped    <= ~a_big;
                        special    <= special_in;
                        rem        <= special_in ? '0 : rem_init;
                        state      <= (special_in || rem_init == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    mant_small <= mant_next;
                    rem        <= rem - k;
                    if (rem == k) state <= DONE;
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_align_denorm.sv
// Directed bench for fp_align_denorm with hand-computed expected values.
module tb_fp_align_denorm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  exp_out;
    logic        sign_big, sign_small;
    logic [26:0] mant_big, mant_small;
    logic        swapped, special;

    int passed = 0;
    int total  = 0;

    fp_align_denorm #(.STEP(4), .MAX_SHIFT(27)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_out(exp_out), .sign_big(sign_big), .sign_small(sign_small),
        .mant_big(mant_big), .mant_small(mant_small),
        .swapped(swapped), .special(special)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic start_op(input string tag, input logic [31:0] va, input logic [31:0] vb);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = va;
        b = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic check_res(input string tag, input logic [7:0] e, input logic sw,
                             input logic sp, input logic [26:0] mb, input logic [26:0] ms);
        check({tag, "_exp_out"}, 32'(exp_out), 32'(e));
        check({tag, "_swapped"}, 32'(swapped), 32'(sw));
        check({tag, "_special"}, 32'(special), 32'(sp));
        check({tag, "_mant_big"}, 32'(mant_big), 32'(mb));
        check({tag, "_mant_small"}, 32'(mant_small), 32'(ms));
    endtask

    task automatic pop(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_pop_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_pop_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mant_small", 32'(mant_small), 32'd0);
        check("rst_exp_out", 32'(exp_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: equal exponents, tie selects A, no shift
        start_op("t1", 32'h3F800000, 32'h3F800000);
        wait_valid("t1", 1);
        check_res("t1", 8'h7F, 1'b0, 1'b0, 27'h4000000, 27'h4000000);
        pop("t1");

        // 2: B larger by 3, one shift cycle; A negative to check sign routing
        start_op("t2", 32'hBF800000, 32'h41000000);
        wait_valid("t2", 2);
        check_res("t2", 8'h82, 1'b1, 1'b0, 27'h4000000, 27'h0800000);
        check("t2_sign_big", 32'(sign_big), 32'd0);
        check("t2_sign_small", 32'(sign_small), 32'd1);
        pop("t2");

        // 3: d=23, sticky collects the lsb of the small fraction
        start_op("t3", 32'h4B000000, 32'h3F800001);
        wait_valid("t3", 7);
        check_res("t3", 8'h96, 1'b0, 1'b0, 27'h4000000, 27'h0000009);
        pop("t3");

        // 4: d=253 clamps to 27, everything collapses into sticky
        start_op("t4", 32'h7F000000, 32'h00800000);
        wait_valid("t4", 8);
        check_res("t4", 8'hFE, 1'b0, 1'b0, 27'h4000000, 27'h0000001);
        pop("t4");

        // zero small operand: clamped shift of zero stays zero
        start_op("tz", 32'h00000000, 32'h3F800000);
        wait_valid("tz", 8);
        check_res("tz", 8'h7F, 1'b1, 1'b0, 27'h4000000, 27'h0000000);
        pop("tz");

        // 5: backpressure while new operands are offered
        start_op("t5", 32'h3F800000, 32'h41000000);
        wait_valid("t5", 2);
        for (int i = 0; i < 5; i++) begin
            a = 32'h40400000 + 32'(i);
            b = 32'h3E000000;
            in_valid = ~in_valid;
            @(posedge clk);
            #1;
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            check("t5_hold_ready", 32'(in_ready), 32'd0);
            check("t5_hold_mant_small", 32'(mant_small), 32'h0800000);
        end
        in_valid = 1'b0;
        check_res("t5", 8'h82, 1'b1, 1'b0, 27'h4000000, 27'h0800000);
        pop("t5");
        @(posedge clk);
        #1;
        check("t5_idle_no_capture", 32'(out_valid), 32'd0);

        // 6: reset during SHIFT discards the operation
        start_op("t6", 32'h4B000000, 32'h3F800001);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_mant_small", 32'(mant_small), 32'd0);
        check("t6_rst_mant_big", 32'(mant_big), 32'd0);
        check("t6_rst_exp_out", 32'(exp_out), 32'd0);
        check("t6_rst_swapped", 32'(swapped), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t6_discarded", 32'(out_valid), 32'd0);

        start_op("t6s", 32'h7F800000, 32'h3F800000);
        wait_valid("t6s", 1);
        check_res("t6s", 8'hFF, 1'b0, 1'b1, 27'h4000000, 27'h4000000);
        pop("t6s");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
